pa_tcipif_req_arb: RTL and testbench
====================================

// Module: pa_tcipif_req_arb
// PURPOSE
//  Two-master arbiter in front of the TCIP slave interface (CLINT/CLIC/SYSMAP register space).
//  Shares the single dbus-style port between master 0 (BMU dbus) and master 1 (debug access path).
//  Grants round-robin and allows one outstanding transaction.
//  Routes the completion, error and read data back to the owning master only.
// PARAMETERS
//  TIMEOUT_W    8    width of the watchdog counter (used only with the optional feature)
//  TIMEOUT_CYC  255  cycles in BUSY before a forced error completion; 1..2^TIMEOUT_W-1
// PORTS
//  forever_cpuclk     in   1   clock
//  cpurst             in   1   asynchronous reset, active high
//  mst_arb_req        in   2   per-master request; bit n = master n; held until grnt
//  mst_arb_addr       in   64  [32n+31:32n] = master n address
//  mst_arb_write      in   2   per-master write flag
//  mst_arb_size       in   4   [2n+1:2n] = master n access size
//  mst_arb_wdata      in   64  [32n+31:32n] = master n write data
//  arb_mst_grnt       out  2   one-hot grant, combinational, same cycle as the slave grant
//  arb_mst_cmplt      out  2   one-hot completion pulse to the owner
//  arb_mst_err        out  2   error with completion, one-hot, valid only with cmplt
//  arb_mst_rdata      out  32  read data, broadcast; qualify with cmplt
//  arb_tcipif_req     out  1   request to the slave port
//  arb_tcipif_addr    out  32  muxed address (0 when arb_tcipif_req=0)
//  arb_tcipif_write   out  1   muxed write flag (0 when idle)
//  arb_tcipif_size    out  2   muxed size (0 when idle)
//  arb_tcipif_wdata   out  32  write data from the owner in BUSY, from the selected master in IDLE
//  tcipif_arb_grnt    in   1   slave accepts the request this cycle
//  tcipif_arb_cmplt   in   1   slave completion pulse
//  tcipif_arb_err     in   1   slave access error, valid with cmplt
//  tcipif_arb_rdata   in   32  slave read data, valid with cmplt
// BEHAVIOUR
//  - State: IDLE / BUSY. Registers: state, owner (1b), prio (1b: next preferred master), optional timer.
//  - Reset: state=IDLE, owner=0, prio=0, timer=0.
//  - Reset values of outputs: all outputs are 0 (all derive from IDLE with no req).
//  - IDLE selection: sel = prio if mst_arb_req[prio], else the other master if it is requesting.
//  - IDLE forwarding: sel fields drive arb_tcipif_* combinationally; arb_tcipif_req=|mst_arb_req.
//  - IDLE grant: on tcipif_arb_grnt, arb_mst_grnt[sel]=1 that cycle. Next cycle: BUSY, owner=sel.
//  - IDLE with no grant: stay IDLE; selection is re-evaluated each cycle, no lock.
//  - BUSY: arb_tcipif_req=0; arb_mst_grnt=0; other requests wait.
//  - BUSY wdata: arb_tcipif_wdata holds owner wdata; the master holds wdata until cmplt.
//  - BUSY completion: on tcipif_arb_cmplt, arb_mst_cmplt[owner]=1, err[owner]=tcipif_arb_err,
//    rdata=tcipif_arb_rdata (same cycle, combinational).
//    Next cycle: IDLE, prio=~owner.
//  - Grant latency: min 1 cycle; back-to-back transactions have one IDLE bubble after each cmplt.
//    No grant is issued in the cmplt cycle.
//  - cmplt in IDLE (stray or late) is discarded: no arb_mst_cmplt, no state change.
//  - Simultaneous requests from both masters: prio wins; the loser is granted after the winner's cmplt.
//  - arb_mst_rdata = 0 whenever no arb_mst_cmplt bit is set.
//  - Reset asserted mid-transaction: drop to IDLE immediately. The slave's later cmplt falls under the
//    IDLE-discard rule.
// CONFIGURATION
//  TCIPIF_ARB_TIMEOUT_EN defined:
//    - The timer clears on entry to BUSY and increments each BUSY cycle without cmplt.
//    - When timer==TIMEOUT_CYC and there is no cmplt: arb_mst_cmplt[owner]=1, err=1, rdata=0,
//      next state IDLE, prio=~owner.
//    - A real cmplt in the same cycle takes precedence over the timeout.
//  TCIPIF_ARB_TIMEOUT_EN undefined: no timer logic; BUSY waits indefinitely for tcipif_arb_cmplt.
// TESTING
//  1 Single request: m0 req, addr=0xE000_0004, grnt in cycle 0; cmplt in cycle 3, rdata=0x1234
//    -> grnt[0] in c0; cmplt[0] in c3, rdata=0x1234, err=0.
//  2 Both masters request after reset -> m0 granted first. After m0 cmplt, m1 granted in the next
//    cycle, not in the cmplt cycle. Then prio=0.
//  3 m1 held requesting during m0 BUSY -> arb_tcipif_req=0 and grnt=0 until m0 cmplt.
//    Check arb_tcipif_addr switches to m1 addr only in IDLE.
//  4 Slave returns cmplt with err=1 for m1 write -> cmplt[1]=1, err[1]=1; m0 sees no outputs.
//  5 Stray tcipif_arb_cmplt in IDLE, and cpurst pulse mid-BUSY -> no arb_mst_cmplt.
//    All outputs 0 after reset; prio=0.
//  6 TIMEOUT_EN, TIMEOUT_CYC=4, slave never completes -> cmplt[owner]+err in cycle 4 of BUSY, rdata=0.
//    A late slave cmplt is then ignored.

Source files
------------

// File: rtl/pa_tcipif_req_arb.sv
// Two-master round-robin arbiter in front of the TCIP slave port, one outstanding transaction.
// Optional watchdog completion enabled by defining TCIPIF_ARB_TIMEOUT_EN.
module pa_tcipif_req_arb #(
    parameter int unsigned TIMEOUT_W   = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst,
    input  logic [1:0]  mst_arb_req,
    input  logic [63:0] mst_arb_addr,
    input  logic [1:0]  mst_arb_write,
    input  logic [3:0]  mst_arb_size,
    input  logic [63:0] mst_arb_wdata,
    output logic [1:0]  arb_mst_grnt,
    output logic [1:0]  arb_mst_cmplt,
    output logic [1:0]  arb_mst_err,
    output logic [31:0] arb_mst_rdata,
    output logic        arb_tcipif_req,
    output logic [31:0] arb_tcipif_addr,
    output logic        arb_tcipif_write,
    output logic [1:0]  arb_tcipif_size,
    output logic [31:0] arb_tcipif_wdata,
    input  logic        tcipif_arb_grnt,
    input  logic        tcipif_arb_cmplt,
    input  logic        tcipif_arb_err,
    input  logic [31:0] tcipif_arb_rdata
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (32'd1 << TIMEOUT_W)) begin : g_bad_cfg
        $error("pa_tcipif_req_arb: TIMEOUT_CYC out of range for TIMEOUT_W");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q,  prio_d;
`ifdef TCIPIF_ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
`endif

    logic [31:0] addr_m  [2];
    logic [31:0] wdata_m [2];
    logic [1:0]  size_m  [2];
    logic        any_req;
    logic        sel;

    always_comb begin
        addr_m[0]  = mst_arb_addr[31:0];
        addr_m[1]  = mst_arb_addr[63:32];
        wdata_m[0] = mst_arb_wdata[31:0];
        wdata_m[1] = mst_arb_wdata[63:32];
        size_m[0]  = mst_arb_size[1:0];
        size_m[1]  = mst_arb_size[3:2];
    end

    // Preferred master wins; otherwise fall back to the other requester.
    always_comb begin
        any_req = |mst_arb_req;
        sel     = prio_q;
        if (!mst_arb_req[prio_q] && mst_arb_req[~prio_q]) begin
            sel = ~prio_q;
        end
    end

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        prio_d           = prio_q;
`ifdef TCIPIF_ARB_TIMEOUT_EN
        timer_d          = timer_q;
`endif
        arb_mst_grnt     = '0;
        arb_mst_cmplt    = '0;
        arb_mst_err      = '0;
        arb_mst_rdata    = '0;
        arb_tcipif_req   = 1'b0;
        arb_tcipif_addr  = '0;
        arb_tcipif_write = 1'b0;
        arb_tcipif_size  = '0;
        arb_tcipif_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    arb_tcipif_req   = 1'b1;
                    arb_tcipif_addr  = addr_m[sel];
                    arb_tcipif_write = mst_arb_write[sel];
                    arb_tcipif_size  = size_m[sel];
                    arb_tcipif_wdata = wdata_m[sel];
                    if (tcipif_arb_grnt) begin
                        arb_mst_grnt[sel] = 1'b1;
                        state_d           = ST_BUSY;
                        owner_d           = sel;
`ifdef TCIPIF_ARB_TIMEOUT_EN
                        timer_d           = '0;
`endif
                    end
                end
            end
            ST_BUSY: begin
                arb_tcipif_wdata = wdata_m[owner_q];
                if (tcipif_arb_cmplt) begin
                    arb_mst_cmplt[owner_q] = 1'b1;
                    arb_mst_err[owner_q]   = tcipif_arb_err;
                    arb_mst_rdata          = tcipif_arb_rdata;
                    state_d                = ST_IDLE;
                    prio_d                 = ~owner_q;
                end
`ifdef TCIPIF_ARB_TIMEOUT_EN
                // Watchdog: force an error completion when the slave goes silent.
                else if (timer_q == TIMEOUT_W'(TIMEOUT_CYC)) begin
                    arb_mst_cmplt[owner_q] = 1'b1;
                    arb_mst_err[owner_q]   = 1'b1;
                    state_d                = ST_IDLE;
                    prio_d                 = ~owner_q;
                end else begin
                    timer_d = timer_q + TIMEOUT_W'(1);
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
`ifdef TCIPIF_ARB_TIMEOUT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
`ifdef TCIPIF_ARB_TIMEOUT_EN
            timer_q <= timer_d;
`endif
        end
    end

endmodule

// File: tb/tb_pa_tcipif_req_arb.sv
// Directed plus randomized bench for pa_tcipif_req_arb against a transaction-level reference model.
module tb_pa_tcipif_req_arb;

`ifdef TCIPIF_ARB_TIMEOUT_EN
    localparam int unsigned TCYC = 4;
`else
    localparam int unsigned TCYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mst_arb_req;
    logic [63:0] mst_arb_addr;
    logic [1:0]  mst_arb_write;
    logic [3:0]  mst_arb_size;
    logic [63:0] mst_arb_wdata;
    logic [1:0]  arb_mst_grnt, arb_mst_cmplt, arb_mst_err;
    logic [31:0] arb_mst_rdata;
    logic        arb_tcipif_req;
    logic [31:0] arb_tcipif_addr;
    logic        arb_tcipif_write;
    logic [1:0]  arb_tcipif_size;
    logic [31:0] arb_tcipif_wdata;
    logic        s_grnt, s_cmplt, s_err;
    logic [31:0] s_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: transaction in flight?, who owns it, who is preferred next, busy cycles elapsed.
    bit          m_busy, m_owner, m_prio;
    int unsigned m_timer;

    // Outputs observed in the most recent cycle, for directed spot checks.
    logic [1:0]  o_grnt, o_cmplt, o_err;
    logic [31:0] o_rdata, o_addr;
    logic        o_req;

    always #5 clk = ~clk;

    pa_tcipif_req_arb #(.TIMEOUT_W(8), .TIMEOUT_CYC(TCYC)) dut (
        .forever_cpuclk   (clk),
        .cpurst           (rst),
        .mst_arb_req      (mst_arb_req),
        .mst_arb_addr     (mst_arb_addr),
        .mst_arb_write    (mst_arb_write),
        .mst_arb_size     (mst_arb_size),
        .mst_arb_wdata    (mst_arb_wdata),
        .arb_mst_grnt     (arb_mst_grnt),
        .arb_mst_cmplt    (arb_mst_cmplt),
        .arb_mst_err      (arb_mst_err),
        .arb_mst_rdata    (arb_mst_rdata),
        .arb_tcipif_req   (arb_tcipif_req),
        .arb_tcipif_addr  (arb_tcipif_addr),
        .arb_tcipif_write (arb_tcipif_write),
        .arb_tcipif_size  (arb_tcipif_size),
        .arb_tcipif_wdata (arb_tcipif_wdata),
        .tcipif_arb_grnt  (s_grnt),
        .tcipif_arb_cmplt (s_cmplt),
        .tcipif_arb_err   (s_err),
        .tcipif_arb_rdata (s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        mst_arb_req = '0; mst_arb_addr = '0; mst_arb_write = '0; mst_arb_size = '0;
        mst_arb_wdata = '0; s_grnt = 0; s_cmplt = 0; s_err = 0; s_rdata = '0;
    endtask

    // One clock: inputs already driven; check at negedge against the model, then advance the model.
    task automatic cyc(input string tag);
        logic [1:0]  e_grnt, e_cmplt, e_err, e_size;
        logic [31:0] e_addr, e_wdata, e_rdata;
        logic        e_req, e_write;
        int          s;
        bit          timeout;
        @(negedge clk);
        e_grnt = 0; e_cmplt = 0; e_err = 0; e_rdata = 0;
        e_req = 0; e_addr = 0; e_write = 0; e_size = 0; e_wdata = 0;
        if (!m_busy) begin
            if (mst_arb_req != 0) begin
                s = mst_arb_req[m_prio] ? int'(m_prio) : int'(!m_prio);
                e_req   = 1;
                e_addr  = mst_arb_addr[32*s +: 32];
                e_write = mst_arb_write[s];
                e_size  = mst_arb_size[2*s +: 2];
                e_wdata = mst_arb_wdata[32*s +: 32];
                if (s_grnt) begin
                    e_grnt[s] = 1;
                    m_busy = 1; m_owner = (s == 1); m_timer = 0;
                end
            end
        end else begin
            s = int'(m_owner);
            e_wdata = mst_arb_wdata[32*s +: 32];
`ifdef TCIPIF_ARB_TIMEOUT_EN
            timeout = !s_cmplt && (m_timer == TCYC);
`else
            timeout = 0;
`endif
            if (s_cmplt || timeout) begin
                e_cmplt[s] = 1;
                e_err[s]   = s_cmplt ? s_err : 1'b1;
                e_rdata    = s_cmplt ? s_rdata : 32'h0;
                m_busy = 0; m_prio = !m_owner;
            end else begin
                m_timer++;
            end
        end
        chk({tag, ".grnt"},   64'(arb_mst_grnt),     64'(e_grnt));
        chk({tag, ".cmplt"},  64'(arb_mst_cmplt),    64'(e_cmplt));
        chk({tag, ".err"},    64'(arb_mst_err),      64'(e_err));
        chk({tag, ".rdata"},  64'(arb_mst_rdata),    64'(e_rdata));
        chk({tag, ".req"},    64'(arb_tcipif_req),   64'(e_req));
        chk({tag, ".addr"},   64'(arb_tcipif_addr),  64'(e_addr));
        chk({tag, ".write"},  64'(arb_tcipif_write), 64'(e_write));
        chk({tag, ".size"},   64'(arb_tcipif_size),  64'(e_size));
        chk({tag, ".wdata"},  64'(arb_tcipif_wdata), 64'(e_wdata));
        o_grnt = arb_mst_grnt; o_cmplt = arb_mst_cmplt; o_err = arb_mst_err;
        o_rdata = arb_mst_rdata; o_addr = arb_tcipif_addr; o_req = arb_tcipif_req;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse; inputs are quiet so every output must read zero.
    task automatic do_reset(input string tag);
        idle_inputs();
        rst = 1;
        #1;
        chk({tag, ".grnt"},  64'(arb_mst_grnt),     64'h0);
        chk({tag, ".cmplt"}, 64'(arb_mst_cmplt),    64'h0);
        chk({tag, ".err"},   64'(arb_mst_err),      64'h0);
        chk({tag, ".rdata"}, 64'(arb_mst_rdata),    64'h0);
        chk({tag, ".req"},   64'(arb_tcipif_req),   64'h0);
        chk({tag, ".addr"},  64'(arb_tcipif_addr),  64'h0);
        chk({tag, ".wdata"}, 64'(arb_tcipif_wdata), 64'h0);
        m_busy = 0; m_owner = 0; m_prio = 0; m_timer = 0;
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 0;
        idle_inputs();
        #2;
        do_reset("rst0");

        // Single m0 read: grant immediately, complete three cycles later.
        mst_arb_req = 2'b01; mst_arb_addr = 64'h0000_0000_E000_0004; mst_arb_size = 4'b0010; s_grnt = 1;
        cyc("t1_c0");
        chk("t1_grnt_c0", 64'(o_grnt), 64'h1);
        mst_arb_req = 0; s_grnt = 0;
        cyc("t1_c1");
        cyc("t1_c2");
        s_cmplt = 1; s_rdata = 32'h1234;
        cyc("t1_c3");
        chk("t1_cmplt", 64'(o_cmplt), 64'h1);
        chk("t1_rdata", 64'(o_rdata), 64'h1234);
        chk("t1_err",   64'(o_err),   64'h0);
        idle_inputs();
        cyc("t1_idle");

        // Both request after reset: m0 first, m1 only after m0's completion bubble.
        do_reset("rst1");
        mst_arb_req = 2'b11; mst_arb_addr = 64'hBBBB_0010_AAAA_0020;
        mst_arb_wdata = 64'h2222_2222_1111_1111; mst_arb_write = 2'b10; s_grnt = 1;
        cyc("t2_c0");
        chk("t2_m0_first", 64'(o_grnt), 64'h1);
        mst_arb_req = 2'b10; s_grnt = 1;
        cyc("t3_busy");
        chk("t3_req_off",  64'(o_req),  64'h0);
        chk("t3_addr_off", 64'(o_addr), 64'h0);
        s_cmplt = 1; s_rdata = 32'hCAFE_F00D;
        cyc("t2_cmplt");
        chk("t2_no_grnt_in_cmplt", 64'(o_grnt), 64'h0);
        s_cmplt = 0; s_rdata = 0;
        cyc("t2_m1");
        chk("t2_m1_grnt", 64'(o_grnt), 64'h2);
        chk("t3_addr_m1", 64'(o_addr), 64'hBBBB_0010);
        mst_arb_req = 0; s_grnt = 0;
        cyc("t4_busy");
        s_cmplt = 1; s_err = 1;
        cyc("t4_err");
        chk("t4_cmplt", 64'(o_cmplt), 64'h2);
        chk("t4_err",   64'(o_err),   64'h2);
        s_cmplt = 0; s_err = 0;
        mst_arb_req = 2'b11; s_grnt = 1;
        cyc("t2_prio0");
        chk("t2_prio_back_to_m0", 64'(o_grnt), 64'h1);

        // Reset mid-BUSY, then a stray completion in IDLE must vanish.
        mst_arb_req = 0; s_grnt = 0;
        cyc("t5_busy");
        do_reset("t5_rst");
        s_cmplt = 1; s_rdata = 32'hDEAD_BEEF;
        cyc("t5_stray");
        chk("t5_stray_cmplt", 64'(o_cmplt), 64'h0);
        idle_inputs();

`ifdef TCIPIF_ARB_TIMEOUT_EN
        // Silent slave: watchdog completes with error on the fifth BUSY cycle.
        mst_arb_req = 2'b10; s_grnt = 1;
        cyc("t6_grnt");
        mst_arb_req = 0; s_grnt = 0;
        for (int i = 0; i < 4; i++) cyc("t6_wait");
        cyc("t6_to");
        chk("t6_to_cmplt", 64'(o_cmplt), 64'h2);
        chk("t6_to_err",   64'(o_err),   64'h2);
        chk("t6_to_rdata", 64'(o_rdata), 64'h0);
        s_cmplt = 1; s_rdata = 32'h5555_AAAA;
        cyc("t6_late");
        chk("t6_late_cmplt", 64'(o_cmplt), 64'h0);
        idle_inputs();
`endif

        // Random traffic, including protocol-agnostic stray grants/completions and resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rnd_rst");
            end else begin
                mst_arb_req   = 2'($urandom);
                mst_arb_addr  = {$urandom, $urandom};
                mst_arb_write = 2'($urandom);
                mst_arb_size  = 4'($urandom);
                mst_arb_wdata = {$urandom, $urandom};
                s_grnt  = 1'($urandom);
                s_cmplt = ($urandom_range(0, 5) == 0);
                s_err   = 1'($urandom);
                s_rdata = $urandom;
                cyc("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
